// File: rtl/lab3_cache_assoc_tag_unit_if.sv
// rtl/lab3_cache_assoc_tag_unit_if.sv - lookup, update, flush and writeback signals of the tag unit
interface lab3_cache_assoc_tag_unit_if #(
    parameter int p_num_ways = 2,
    parameter int p_num_sets = 16
);
    localparam int WAYB = $clog2(p_num_ways);
    localparam int IDX  = $clog2(p_num_sets);

    logic            lookup_val;
    logic            lookup_rdy;
    logic [31:0]     lookup_addr;
    logic            resp_val;
    logic            resp_hit;
    logic [WAYB-1:0] resp_way;
    logic            resp_victim_valid;
    logic            resp_victim_dirty;
    logic [31:0]     resp_victim_addr;
    logic            fill_en;
    logic [WAYB-1:0] fill_way;
    logic [31:0]     fill_addr;
    logic            fill_dirty;
    logic            touch_en;
    logic [WAYB-1:0] touch_way;
    logic [31:0]     touch_addr;
    logic            touch_dirty;
    logic            flush_req;
    logic            flush_busy;
    logic            flush_done;
    logic            wb_val;
    logic            wb_rdy;
    logic [IDX-1:0]  wb_idx;
    logic [WAYB-1:0] wb_way;
    logic [31:0]     wb_addr;

    modport master (
        output lookup_val, lookup_addr,
        output fill_en, fill_way, fill_addr, fill_dirty,
        output touch_en, touch_way, touch_addr, touch_dirty,
        output flush_req, wb_rdy,
        input  lookup_rdy, resp_val, resp_hit, resp_way,
        input  resp_victim_valid, resp_victim_dirty, resp_victim_addr,
        input  flush_busy, flush_done, wb_val, wb_idx, wb_way, wb_addr
    );

    modport slave (
        input  lookup_val, lookup_addr,
        input  fill_en, fill_way, fill_addr, fill_dirty,
        input  touch_en, touch_way, touch_addr, touch_dirty,
        input  flush_req, wb_rdy,
        output lookup_rdy, resp_val, resp_hit, resp_way,
        output resp_victim_valid, resp_victim_dirty, resp_victim_addr,
        output flush_busy, flush_done, wb_val, wb_idx, wb_way, wb_addr
    );
endinterface

// File: rtl/lab3_cache_assoc_tag_unit.sv
// rtl/lab3_cache_assoc_tag_unit.sv - set-associative tag/valid/dirty/replacement store with flush walker
// Define LAB3_CACHE_ASSOC_PLRU_EN for tree pseudo-LRU replacement; round-robin otherwise.
module lab3_cache_assoc_tag_unit #(
    parameter int p_num_ways    = 2,
    parameter int p_num_sets    = 16,
    parameter int p_line_nbytes = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    lab3_cache_assoc_tag_unit_if.slave   bus
);
    localparam int W    = p_num_ways;
    localparam int S    = p_num_sets;
    localparam int OFF  = $clog2(p_line_nbytes);
    localparam int IDX  = $clog2(p_num_sets);
    localparam int TAG  = 32 - IDX - OFF;
    localparam int WAYB = $clog2(p_num_ways);
    localparam int CNTB = IDX + WAYB;

`ifdef LAB3_CACHE_ASSOC_PLRU_EN
    localparam int REPL_W = W - 1;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit 0 points at the lower half.
    function automatic logic [WAYB-1:0] repl_victim(input logic [REPL_W-1:0] t);
        int n;
        n = 0;
        for (int l = 0; l < WAYB; l++) n = 2 * n + 1 + int'(t[n]);
        return WAYB'(n - (W - 1));
    endfunction

    function automatic logic [REPL_W-1:0] repl_fill(input logic [REPL_W-1:0] t,
                                                    input logic [WAYB-1:0] way);
        int   n;
        logic d;
        n = 0;
        for (int l = 0; l < WAYB; l++) begin
            d    = way[WAYB-1-l];
            t[n] = ~d;
            n    = 2 * n + 1 + int'(d);
        end
        return t;
    endfunction

    function automatic logic [REPL_W-1:0] repl_touch(input logic [REPL_W-1:0] t,
                                                     input logic [WAYB-1:0] way);
        return repl_fill(t, way);
    endfunction
`else
    localparam int REPL_W = WAYB;

    function automatic logic [WAYB-1:0] repl_victim(input logic [REPL_W-1:0] t);
        return t;
    endfunction

    function automatic logic [REPL_W-1:0] repl_fill(input logic [REPL_W-1:0] t,
                                                    input logic [WAYB-1:0] way);
        logic unused_way;
        unused_way = ^way;
        return t + 1'b1;
    endfunction

    function automatic logic [REPL_W-1:0] repl_touch(input logic [REPL_W-1:0] t,
                                                     input logic [WAYB-1:0] way);
        logic unused_way;
        unused_way = ^way;
        return t;
    endfunction
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t           r_state;
    logic [CNTB-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_valid [S];
    logic [W-1:0]     r_dirty [S];
    logic [TAG-1:0]   r_tag   [S][W];
    logic [REPL_W-1:0] r_repl [S];

    logic             r_resp_val;
    logic             r_resp_hit;
    logic [WAYB-1:0]  r_resp_way;
    logic             r_resp_vv;
    logic             r_resp_vd;
    logic [31:0]      r_resp_va;

    logic [IDX-1:0]   w_lk_idx;
    logic [TAG-1:0]   w_lk_tag;
    logic             w_hit;
    logic [WAYB-1:0]  w_hit_way;
    logic             w_inv_found;
    logic [WAYB-1:0]  w_inv_way;
    logic [WAYB-1:0]  w_victim;
    logic             w_lookup_rdy;
    logic             w_accept;
    logic [IDX-1:0]   w_fl_idx;
    logic [TAG-1:0]   w_fl_tag;
    logic [IDX-1:0]   w_tc_idx;
    logic [IDX-1:0]   w_sc_idx;
    logic [WAYB-1:0]  w_sc_way;
    logic             w_sc_live;
    logic             w_advance;
    logic             w_unused;

    assign w_lk_idx = bus.lookup_addr[OFF+IDX-1:OFF];
    assign w_lk_tag = bus.lookup_addr[31:OFF+IDX];
    assign w_fl_idx = bus.fill_addr[OFF+IDX-1:OFF];
    assign w_fl_tag = bus.fill_addr[31:OFF+IDX];
    assign w_tc_idx = bus.touch_addr[OFF+IDX-1:OFF];
    assign w_unused = ^{bus.lookup_addr[OFF-1:0], bus.fill_addr[OFF-1:0],
                        bus.touch_addr[OFF-1:0], bus.touch_addr[31:OFF+IDX]};

    assign w_lookup_rdy = (r_state == ST_IDLE) & ~bus.flush_req & ~reset;
    assign w_accept     = bus.lookup_val & w_lookup_rdy;

    // Descending scan so the lowest-numbered invalid way is the one left standing.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = W - 1; w >= 0; w--) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAYB'(w);
            end
            if (!r_valid[w_lk_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAYB'(w);
            end
        end
        w_victim = w_inv_found ? w_inv_way : repl_victim(r_repl[w_lk_idx]);
    end

    // Counter layout {set, way} gives the way-minor, set-major visiting order.
    assign w_sc_idx  = r_cnt[CNTB-1:WAYB];
    assign w_sc_way  = r_cnt[WAYB-1:0];
    assign w_sc_live = r_valid[w_sc_idx][w_sc_way] & r_dirty[w_sc_idx][w_sc_way];
    assign w_advance = (r_state == ST_SCAN) & (~w_sc_live | bus.wb_rdy);

    assign bus.lookup_rdy        = w_lookup_rdy;
    assign bus.resp_val          = r_resp_val;
    assign bus.resp_hit          = r_resp_hit;
    assign bus.resp_way          = r_resp_way;
    assign bus.resp_victim_valid = r_resp_vv;
    assign bus.resp_victim_dirty = r_resp_vd;
    assign bus.resp_victim_addr  = r_resp_va;
    assign bus.flush_busy        = r_busy;
    assign bus.flush_done        = r_done;
    assign bus.wb_val            = (r_state == ST_SCAN) & w_sc_live;
    assign bus.wb_idx            = w_sc_idx;
    assign bus.wb_way            = w_sc_way;
    assign bus.wb_addr           = {r_tag[w_sc_idx][w_sc_way], w_sc_idx, {OFF{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_resp_val <= 1'b0;
            r_resp_hit <= 1'b0;
            r_resp_way <= '0;
            r_resp_vv  <= 1'b0;
            r_resp_vd  <= 1'b0;
            r_resp_va  <= '0;
            for (int s = 0; s < S; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_repl[s]  <= '0;
                for (int w = 0; w < W; w++) r_tag[s][w] <= '0;
            end
        end else begin
            r_resp_val <= w_accept;
            if (w_accept) begin
                r_resp_hit <= w_hit;
                r_resp_way <= w_hit ? w_hit_way : w_victim;
                r_resp_vv  <= r_valid[w_lk_idx][w_victim];
                r_resp_vd  <= r_dirty[w_lk_idx][w_victim];
                r_resp_va  <= {r_tag[w_lk_idx][w_victim], w_lk_idx, {OFF{1'b0}}};
            end

            // Fill is written after touch so it overrides on a shared set or (set, way).
            if (r_state == ST_IDLE) begin
                if (bus.touch_en) begin
                    r_dirty[w_tc_idx][bus.touch_way] <= r_dirty[w_tc_idx][bus.touch_way] | bus.touch_dirty;
                    r_repl[w_tc_idx] <= repl_touch(r_repl[w_tc_idx], bus.touch_way);
                end
                if (bus.fill_en) begin
                    r_tag[w_fl_idx][bus.fill_way]   <= w_fl_tag;
                    r_valid[w_fl_idx][bus.fill_way] <= 1'b1;
                    r_dirty[w_fl_idx][bus.fill_way] <= bus.fill_dirty;
                    r_repl[w_fl_idx] <= repl_fill(r_repl[w_fl_idx], bus.fill_way);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.flush_req) begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_advance) begin
                        if (w_sc_live) r_dirty[w_sc_idx][w_sc_way] <= 1'b0;
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lab3_cache_assoc_tag_unit.sv
// tb/tb_lab3_cache_assoc_tag_unit.sv - directed bench for the associative tag unit (2 ways, 16 sets, 64B lines)
module tb_lab3_cache_assoc_tag_unit;
    localparam int OP_FILL  = 0;
    localparam int OP_TOUCH = 1;
    localparam int OP_LOOK  = 2;
    localparam int NV       = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lab3_cache_assoc_tag_unit_if #(.p_num_ways(2), .p_num_sets(16)) u_if ();

    lab3_cache_assoc_tag_unit #(
        .p_num_ways(2), .p_num_sets(16), .p_line_nbytes(64)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    typedef struct {
        int          op;
        logic        way;
        logic [31:0] addr;
        logic        dirty;
        logic        e_hit;
        logic        e_way;
        logic        e_vv;
        logic        e_vd;
        logic [31:0] e_va;
        logic        chk_victim;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [31:0] a);
        u_if.lookup_val  = 1'b1;
        u_if.lookup_addr = a;
        tick();
        u_if.lookup_val  = 1'b0;
    endtask

    initial begin
        int scan, stalls, offers, resp_seen, rdy_seen, c;
        logic done_seen;
        logic [31:0] got_addr [2];
        logic [3:0]  got_idx0;
        logic        got_way0;

        vecs[0]  = '{OP_LOOK,  1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1};
        vecs[1]  = '{OP_FILL,  1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{OP_LOOK,  1'b0, 32'h0000_1044, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{OP_FILL,  1'b1, 32'h0000_2040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{OP_LOOK,  1'b0, 32'h0000_3040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1040, 1'b1};
        vecs[5]  = '{OP_TOUCH, 1'b0, 32'h0000_1040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
`ifdef LAB3_CACHE_ASSOC_PLRU_EN
        vecs[6]  = '{OP_LOOK,  1'b0, 32'h0000_3040, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2040, 1'b1};
`else
        vecs[6]  = '{OP_LOOK,  1'b0, 32'h0000_3040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1040, 1'b1};
`endif
        vecs[7]  = '{OP_FILL,  1'b0, 32'h0000_7FC0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[8]  = '{OP_LOOK,  1'b0, 32'h0000_7FC0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{OP_LOOK,  1'b0, 32'h0000_2040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{OP_LOOK,  1'b0, 32'h0000_8FC0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_03C0, 1'b1};
        vecs[11] = '{OP_LOOK,  1'b0, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 1'b1};
        vecs[12] = '{OP_LOOK,  1'b0, 32'h0000_1040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};

        u_if.lookup_val = 1'b0; u_if.lookup_addr = '0;
        u_if.fill_en = 1'b0; u_if.fill_way = '0; u_if.fill_addr = '0; u_if.fill_dirty = 1'b0;
        u_if.touch_en = 1'b0; u_if.touch_way = '0; u_if.touch_addr = '0; u_if.touch_dirty = 1'b0;
        u_if.flush_req = 1'b0; u_if.wb_rdy = 1'b0;
        reset = 1'b1;
        #12;
        check("reset_lookup_rdy", u_if.lookup_rdy, 0);
        check("reset_resp_val",   u_if.resp_val, 0);
        check("reset_flush_busy", u_if.flush_busy, 0);
        check("reset_flush_done", u_if.flush_done, 0);
        check("reset_wb_val",     u_if.wb_val, 0);
        reset = 1'b0;
        tick();
        check("idle_lookup_rdy", u_if.lookup_rdy, 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].op == OP_LOOK) begin
                do_lookup(vecs[i].addr);
                check($sformatf("v%0d_resp_val", i), u_if.resp_val, 1);
                check($sformatf("v%0d_hit", i), u_if.resp_hit, vecs[i].e_hit);
                check($sformatf("v%0d_way", i), u_if.resp_way, vecs[i].e_way);
                if (vecs[i].chk_victim) begin
                    check($sformatf("v%0d_victim_valid", i), u_if.resp_victim_valid, vecs[i].e_vv);
                    check($sformatf("v%0d_victim_dirty", i), u_if.resp_victim_dirty, vecs[i].e_vd);
                    check($sformatf("v%0d_victim_addr", i), u_if.resp_victim_addr, vecs[i].e_va);
                end
            end else begin
                u_if.fill_en    = (vecs[i].op == OP_FILL);
                u_if.fill_way   = vecs[i].way;
                u_if.fill_addr  = vecs[i].addr;
                u_if.fill_dirty = vecs[i].dirty;
                u_if.touch_en   = (vecs[i].op == OP_TOUCH);
                u_if.touch_way  = vecs[i].way;
                u_if.touch_addr = vecs[i].addr;
                u_if.touch_dirty = vecs[i].dirty;
                tick();
                u_if.fill_en  = 1'b0;
                u_if.touch_en = 1'b0;
            end
        end

        tick();
        check("resp_val_pulse_ends", u_if.resp_val, 0);
        check("resp_hit_holds", u_if.resp_hit, 1);

        // Back-to-back lookups, one per cycle.
        u_if.lookup_val = 1'b1; u_if.lookup_addr = 32'h0000_2040;
        tick();
        check("b2b_first_way", u_if.resp_way, 1);
        u_if.lookup_addr = 32'h0000_7FC0;
        tick();
        u_if.lookup_val = 1'b0;
        check("b2b_second_val", u_if.resp_val, 1);
        check("b2b_second_way", u_if.resp_way, 0);

        // Fill and touch on the same (set, way): the clean fill must win over touch_dirty.
        u_if.fill_en = 1'b1; u_if.fill_way = 1'b0; u_if.fill_addr = 32'h0000_0080; u_if.fill_dirty = 1'b0;
        u_if.touch_en = 1'b1; u_if.touch_way = 1'b0; u_if.touch_addr = 32'h0000_0080; u_if.touch_dirty = 1'b1;
        tick();
        u_if.touch_en = 1'b0;
        u_if.fill_way = 1'b1; u_if.fill_addr = 32'h0000_0480;
        tick();
        u_if.fill_en = 1'b0;
        do_lookup(32'h0000_1080);
        check("same_entry_victim_way", u_if.resp_way, 0);
        check("same_entry_victim_dirty", u_if.resp_victim_dirty, 0);
        check("same_entry_victim_addr", u_if.resp_victim_addr, 32'h0000_0080);
        tick();

        // Flush with a 3-cycle stall on the first offer, plus disturbances during SCAN.
        u_if.lookup_val = 1'b1; u_if.lookup_addr = 32'h0000_2040;
        u_if.flush_req = 1'b1;
        #1;
        check("rdy_low_on_flush_req", u_if.lookup_rdy, 0);
        tick();
        u_if.flush_req = 1'b0;
        scan = 0; stalls = 0; offers = 0; resp_seen = 0; rdy_seen = 0; done_seen = 1'b0;
        got_addr[0] = '0; got_addr[1] = '0; got_idx0 = '0; got_way0 = 1'b0;
        for (c = 0; c < 200; c++) begin
            if (u_if.resp_val) resp_seen++;
            if (u_if.lookup_rdy) rdy_seen++;
            if (u_if.flush_done) begin
                done_seen = 1'b1;
                break;
            end
            if (u_if.flush_busy) scan++;
            u_if.flush_req  = (scan == 5);
            u_if.fill_en    = (scan == 6);
            u_if.fill_way   = 1'b1;
            u_if.fill_addr  = 32'h0000_5040;
            u_if.fill_dirty = 1'b1;
            if (u_if.wb_val) begin
                if (offers == 0 && stalls < 3) begin
                    u_if.wb_rdy = 1'b0;
                    check($sformatf("wb_addr_hold_%0d", stalls), u_if.wb_addr, 32'h0000_2040);
                    stalls++;
                end else begin
                    u_if.wb_rdy = 1'b1;
                    if (offers == 0) begin
                        got_idx0 = u_if.wb_idx;
                        got_way0 = u_if.wb_way;
                    end
                    if (offers < 2) got_addr[offers] = u_if.wb_addr;
                    offers++;
                end
            end else begin
                u_if.wb_rdy = 1'b0;
            end
            tick();
        end
        check("flush_done_seen", done_seen, 1);
        check("flush_busy_in_done", u_if.flush_busy, 0);
        check("lookup_rdy_in_done", u_if.lookup_rdy, 0);
        u_if.lookup_val = 1'b0; u_if.flush_req = 1'b0; u_if.fill_en = 1'b0; u_if.wb_rdy = 1'b0;
        check("flush_scan_cycles", scan, 35);
        check("flush_offers", offers, 2);
        check("wb_first_addr", got_addr[0], 32'h0000_2040);
        check("wb_first_idx", got_idx0, 1);
        check("wb_first_way", got_way0, 1);
        check("wb_second_addr", got_addr[1], 32'h0000_7FC0);
        check("no_resp_during_flush", resp_seen, 0);
        check("no_rdy_during_flush", rdy_seen, 0);
        tick();
        check("flush_done_single_pulse", u_if.flush_done, 0);
        check("second_flush_req_ignored", u_if.flush_busy, 0);

        do_lookup(32'h0000_2040);
        check("post_flush_hit", u_if.resp_hit, 1);
        check("post_flush_way", u_if.resp_way, 1);
        check("post_flush_victim_dirty", u_if.resp_victim_dirty, 0);

        // Reset while a writeback offer is pending.
        u_if.fill_en = 1'b1; u_if.fill_way = 1'b0; u_if.fill_addr = 32'h0000_1040; u_if.fill_dirty = 1'b1;
        tick();
        u_if.fill_en = 1'b0;
        u_if.flush_req = 1'b1;
        tick();
        u_if.flush_req = 1'b0;
        for (c = 0; c < 40; c++) begin
            if (u_if.wb_val) break;
            tick();
        end
        check("wb_val_before_reset", u_if.wb_val, 1);
        reset = 1'b1;
        #1;
        check("async_reset_wb_val", u_if.wb_val, 0);
        check("async_reset_flush_busy", u_if.flush_busy, 0);
        check("async_reset_resp_val", u_if.resp_val, 0);
        check("async_reset_flush_done", u_if.flush_done, 0);
        #10;
        reset = 1'b0;
        tick();
        do_lookup(32'h0000_1040);
        check("after_reset_miss_a", u_if.resp_hit, 0);
        check("after_reset_victim_valid_a", u_if.resp_victim_valid, 0);
        do_lookup(32'h0000_7FC0);
        check("after_reset_miss_b", u_if.resp_hit, 0);
        tick();
        check("after_reset_no_done", u_if.flush_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
